// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the data memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_mem_resp_pkg;

   localparam int WORD_W              = 32;
   localparam int DEFAULT_DEPTH       = 64;
   localparam int DEFAULT_WAIT_CYCLES = 2;
   localparam int CNT_W               = 4;   // holds wait-state counts 0..15

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/data_mem_array.sv
// Word storage: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read is combinational from the index.
// Backpressure: none, the caller decides when to write and when to sample.
module data_mem_array
   import data_mem_resp_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   // Contents deliberately survive reset, so the array has no reset input.
   logic [WORD_W-1:0] mem_q [DEPTH];

   // Commit one word per enabled edge.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_resp.sv
// Single-outstanding memory responder with programmable wait states; optional macro DATA_MEM_RESP_ALIGN_CHECK_EN flags misaligned requests.
// Latency: rsp_valid first visible WAIT_CYCLES+1 cycles after the acceptance edge.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready.
module data_mem_resp
   import data_mem_resp_pkg::*;
#(
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q;
   logic [AW-1:0]     idx_q;
   logic [WORD_W-1:0] wdata_q;
   logic [WORD_W-1:0] rdata_q;

   logic              accept;
   logic              enter_resp;
   logic              cur_we;
   logic [AW-1:0]     cur_idx;
   logic [WORD_W-1:0] cur_wdata;
   logic              cur_mis;
   logic              mem_we;
   logic [WORD_W-1:0] mem_rdata;

   // Address bits above the word index never matter; the array wraps.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:AW+2];

   assign accept     = (state_q == IDLE) && req_valid;
   assign enter_resp = (state_d == RESP) && (state_q != RESP);

   // With zero wait states the commit happens on the acceptance edge itself,
   // so the live request is used in IDLE and the captured copy afterwards.
   assign cur_we    = (state_q == IDLE) ? req_we             : we_q;
   assign cur_idx   = (state_q == IDLE) ? req_addr[AW+1:2]   : idx_q;
   assign cur_wdata = (state_q == IDLE) ? req_wdata          : wdata_q;

`ifdef DATA_MEM_RESP_ALIGN_CHECK_EN
   logic mis_q;
   logic err_q;

   assign cur_mis = (state_q == IDLE) ? (req_addr[1:0] != 2'b00) : mis_q;

   // Misalignment flag travels with the request and becomes the error response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mis_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         if (accept)     mis_q <= cur_mis;
         if (enter_resp) err_q <= cur_mis;
      end
   end
`else
   logic unused_addr_lo;
   assign unused_addr_lo = ^req_addr[1:0];
   assign cur_mis        = 1'b0;
`endif

   // Writes commit only on the edge entering RESP, so an abort discards them.
   assign mem_we = enter_resp && cur_we && !cur_mis;

   data_mem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (cur_idx),
      .wdata_i (cur_wdata),
      .raddr_i (cur_idx),
      .rdata_o (mem_rdata)
   );

   // FSM state and wait counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: accept in IDLE, count down in WAIT, wait for the handshake in RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LD;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= 1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decode directly from state and the response registers.
   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      rsp_rdata = rdata_q;
`ifdef DATA_MEM_RESP_ALIGN_CHECK_EN
      rsp_err   = err_q;
`else
      rsp_err   = 1'b0;
`endif
   end

   // Capture the request on acceptance and sample read data entering RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
         end
         if (enter_resp) begin
            rdata_q <= (cur_we || cur_mis) ? '0 : mem_rdata;
         end
      end
   end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 64, number of 32-bit words stored (power of two, >= 2).
- WAIT_CYCLES, 2, extra wait states between request acceptance and response (0..15).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- req_valid, in, 1, processor request present.
- req_ready, out, 1, responder accepts a request this cycle.
- req_we, in, 1, 1 = write, 0 = read.
- req_addr, in, 32, byte address.
- req_wdata, in, 32, write data.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, processor accepts the response.
- rsp_rdata, out, 32, read data; 0 for writes.
- rsp_err, out, 1, error flag (see Configuration).

Function
REQ-003 FSM states SHALL be IDLE, WAIT, RESP; IDLE is the only state with req_ready=1.
REQ-004 In IDLE, req_valid=1 SHALL be the acceptance event: capture req_we, req_addr, req_wdata; go to WAIT with counter=WAIT_CYCLES, or directly to RESP if WAIT_CYCLES=0.
REQ-005 In WAIT, the counter SHALL decrement each cycle; on the cycle it reads 1, the FSM SHALL go to RESP.
REQ-006 rsp_valid SHALL first assert exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-007 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH.
REQ-008 A write SHALL update storage on the edge entering RESP; rsp_rdata SHALL be 0 for a write.
REQ-009 Read data SHALL be sampled on the edge entering RESP and held stable while rsp_valid=1.
REQ-010 In RESP, rsp_valid SHALL stay 1 and all response outputs SHALL stay stable until rsp_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-011 A request SHALL NOT be accepted in the same cycle as a response handshake; back-to-back transfers SHALL therefore be spaced by at least WAIT_CYCLES+2 cycles.
REQ-012 req_* inputs outside IDLE SHALL be ignored.

Reset
REQ-013 reset=0 SHALL force IDLE immediately, with req_ready=1 once released; rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-014 Reset during WAIT or RESP SHALL abort the transaction: a write not yet committed SHALL be discarded, and no response SHALL be issued.
REQ-015 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-016 With DATA_MEM_RESP_ALIGN_CHECK_EN defined, a request with req_addr[1:0]!=0 SHALL complete with normal latency and rsp_err=1, rsp_rdata=0, and no storage update.
REQ-017 Without DATA_MEM_RESP_ALIGN_CHECK_EN, rsp_err SHALL be tied 0 and req_addr[1:0] SHALL be ignored.

Structure
REQ-018 Package data_mem_resp_pkg SHALL hold the FSM state enum, the default DEPTH and WAIT_CYCLES constants, and the word-width constant of 32.
REQ-019 Storage SHALL be a sub-module, data_mem_array, with one synchronous write port and one read port; the FSM and counter SHALL live in data_mem_resp.

Verification
REQ-020 Reset, then WAIT_CYCLES=2: write 0xDEADBEEF to 0x10, then read 0x10 -> each rsp_valid arrives 3 cycles after acceptance; the read returns 0xDEADBEEF and the write response returns rsp_rdata=0.
REQ-021 Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable; req_ready=0 throughout; IDLE is re-entered the cycle after rsp_ready=1.
REQ-022 DEPTH=64: write 0x1234 to 0x100, then read 0x000 -> returns 0x1234 (wrap).
REQ-023 Assert reset=0 mid-WAIT on a write of 0xCAFE to 0x20 -> no rsp_valid; a later read of 0x20 returns the prior value.
REQ-024 WAIT_CYCLES=0 -> rsp_valid appears 1 cycle after acceptance.
REQ-025 With DATA_MEM_RESP_ALIGN_CHECK_EN: write to 0x22 -> rsp_err=1 and storage is unchanged; without the macro, the same write updates word 8 and rsp_err=0.
